// File: rtl/lbm_pkg.sv
// lbm_pkg: shared types and constants for the LBM node control path.
// Lattice directions, sequencer states and small helpers live here.
package lbm_pkg;

  localparam int Q          = 9;
  localparam int DIR_W      = 4;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    ACCUM,
    DIVX_START,
    DIVX_WAIT,
    DIVY_START,
    DIVY_WAIT,
    WR_MACRO,
    FEQ,
    COLLIDE,
    NEXT
  } seq_state_t;

  function automatic logic [Q-1:0] dir_onehot(
    input logic [DIR_W-1:0] d
  );
    return Q'(1) << d;
  endfunction

endpackage

// File: rtl/lbm_div_watchdog.sv
// lbm_div_watchdog: loadable down-counter guarding divider waits.
// expired is high once the loaded budget has been counted out.
module lbm_div_watchdog #(
  parameter int DIV_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(DIV_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Loaded with TIMEOUT-1 so the last permitted wait cycle sees zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(DIV_TIMEOUT - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/lbm_node_sequencer.sv
// lbm_node_sequencer: steps every lattice node through accumulate,
// divide, macro write, feq load and collide, with a divider watchdog.
module lbm_node_sequencer
  import lbm_pkg::*;
#(
  parameter int GRID_DIM    = 256,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [$clog2(GRID_DIM)-1:0] node_addr,
  output logic [DIR_W-1:0]            dir,
  output logic                        fin_rd_en,
  output logic                        acc_clr,
  output logic                        LD_EN_P,
  output logic                        LD_EN_PUX,
  output logic                        LD_EN_PUY,
  output logic                        div_start,
  output logic                        div_sel,
  input  logic                        div_valid,
  output logic                        LD_EN_UX,
  output logic                        LD_EN_UY,
  output logic                        WE_p_mem,
  output logic                        WE_ux_mem,
  output logic                        WE_uy_mem,
  output logic [Q-1:0]                LD_EN_FEQ,
  output logic                        WE_feq_mem,
  output logic                        WE_fout_mem
);

  localparam int AW = $clog2(GRID_DIM);
  localparam logic [AW-1:0] LAST_NODE = AW'(GRID_DIM - 1);
  localparam logic [DIR_W-1:0] ACC_LAST = DIR_W'(Q);
  localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(Q - 1);
  localparam logic [DIR_W-1:0] ONE = DIR_W'(1);

  seq_state_t       state;
  logic [DIR_W-1:0] step;
  logic             ld_acc;
  logic             we_macro;
  logic             wd_load;
  logic             wd_en;
  logic             wd_expired;

  assign wd_load = (state == DIVX_START) || (state == DIVY_START);
  assign wd_en   = (state == DIVX_WAIT) || (state == DIVY_WAIT);

  lbm_div_watchdog #(
    .DIV_TIMEOUT(DIV_TIMEOUT)
  ) u_wd (
    .clk    (Clk),
    .rst_n  (Reset),
    .load   (wd_load),
    .en     (wd_en),
    .expired(wd_expired)
  );

  assign LD_EN_P   = ld_acc;
  assign LD_EN_PUX = ld_acc;
  assign LD_EN_PUY = ld_acc;
  assign WE_p_mem  = we_macro;
  assign WE_ux_mem = we_macro;
  assign WE_uy_mem = we_macro;

  // Every output is set on the transition into the state that owns it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      step        <= '0;
      node_addr   <= '0;
      dir         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      fin_rd_en   <= 1'b0;
      acc_clr     <= 1'b0;
      ld_acc      <= 1'b0;
      div_start   <= 1'b0;
      div_sel     <= 1'b0;
      LD_EN_UX    <= 1'b0;
      LD_EN_UY    <= 1'b0;
      we_macro    <= 1'b0;
      LD_EN_FEQ   <= '0;
      WE_feq_mem  <= 1'b0;
      WE_fout_mem <= 1'b0;
    end else begin
      done        <= 1'b0;
      dir         <= '0;
      fin_rd_en   <= 1'b0;
      acc_clr     <= 1'b0;
      ld_acc      <= 1'b0;
      div_start   <= 1'b0;
      div_sel     <= 1'b0;
      LD_EN_UX    <= 1'b0;
      LD_EN_UY    <= 1'b0;
      we_macro    <= 1'b0;
      LD_EN_FEQ   <= '0;
      WE_feq_mem  <= 1'b0;
      WE_fout_mem <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= CLR;
            err     <= 1'b0;
            busy    <= 1'b1;
            acc_clr <= 1'b1;
          end
        end
        CLR: begin
          state     <= ACCUM;
          step      <= '0;
          fin_rd_en <= 1'b1;
        end
        // Read of direction k lands one cycle later, hence the skew.
        ACCUM: begin
          if (step == ACC_LAST) begin
            state     <= DIVX_START;
            div_start <= 1'b1;
          end else begin
            step   <= step + ONE;
            ld_acc <= 1'b1;
            if (step < DIR_LAST) begin
              fin_rd_en <= 1'b1;
              dir       <= step + ONE;
            end
          end
        end
        DIVX_START: begin
          state <= DIVX_WAIT;
        end
        DIVX_WAIT: begin
          if (div_valid) begin
            state     <= DIVY_START;
            LD_EN_UX  <= 1'b1;
            div_start <= 1'b1;
            div_sel   <= 1'b1;
          end else if (wd_expired) begin
            state     <= IDLE;
            err       <= 1'b1;
            busy      <= 1'b0;
            node_addr <= '0;
          end
        end
        DIVY_START: begin
          state   <= DIVY_WAIT;
          div_sel <= 1'b1;
        end
        DIVY_WAIT: begin
          if (div_valid) begin
            state    <= WR_MACRO;
            LD_EN_UY <= 1'b1;
            we_macro <= 1'b1;
          end else if (wd_expired) begin
            state     <= IDLE;
            err       <= 1'b1;
            busy      <= 1'b0;
            node_addr <= '0;
          end else begin
            div_sel <= 1'b1;
          end
        end
        WR_MACRO: begin
          state      <= FEQ;
          step       <= '0;
          LD_EN_FEQ  <= dir_onehot('0);
          WE_feq_mem <= 1'b1;
        end
        FEQ: begin
          if (step == DIR_LAST) begin
            state       <= COLLIDE;
            step        <= '0;
            WE_fout_mem <= 1'b1;
          end else begin
            step       <= step + ONE;
            dir        <= step + ONE;
            LD_EN_FEQ  <= dir_onehot(step + ONE);
            WE_feq_mem <= 1'b1;
          end
        end
        COLLIDE: begin
          if (step == DIR_LAST) begin
            state <= NEXT;
            step  <= '0;
          end else begin
            step        <= step + ONE;
            dir         <= step + ONE;
            WE_fout_mem <= 1'b1;
          end
        end
        NEXT: begin
          if (node_addr == LAST_NODE) begin
            state     <= IDLE;
            node_addr <= '0;
            done      <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state     <= CLR;
            node_addr <= node_addr + AW'(1);
            acc_clr   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lbm_node_sequencer.sv
// tb_lbm_node_sequencer: randomized bench against a per-cycle trace
// model of the node sequence built from latencies chosen by the bench.
module tb_lbm_node_sequencer;

  localparam int GD = 4;
  localparam int TO = 64;

  typedef struct {
    bit       busy;
    bit       done;
    bit       err;
    int       node;
    int       dir;
    bit       dchk;
    bit       rd;
    bit       clr;
    bit       acc;
    bit       dst;
    bit       dsel;
    bit       lux;
    bit       luy;
    bit       wmac;
    bit [8:0] feq;
    bit       wfeq;
    bit       wfout;
    bit       wt;
  } rec_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       start = 1'b0;
  logic       div_valid = 1'b0;
  logic       busy, done, err;
  logic [1:0] node_addr;
  logic [3:0] dir;
  logic       fin_rd_en, acc_clr;
  logic       LD_EN_P, LD_EN_PUX, LD_EN_PUY;
  logic       div_start, div_sel;
  logic       LD_EN_UX, LD_EN_UY;
  logic       WE_p_mem, WE_ux_mem, WE_uy_mem;
  logic [8:0] LD_EN_FEQ;
  logic       WE_feq_mem, WE_fout_mem;

  always #5 Clk = ~Clk;

  lbm_node_sequencer #(
    .GRID_DIM   (GD),
    .DIV_TIMEOUT(TO)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .node_addr  (node_addr),
    .dir        (dir),
    .fin_rd_en  (fin_rd_en),
    .acc_clr    (acc_clr),
    .LD_EN_P    (LD_EN_P),
    .LD_EN_PUX  (LD_EN_PUX),
    .LD_EN_PUY  (LD_EN_PUY),
    .div_start  (div_start),
    .div_sel    (div_sel),
    .div_valid  (div_valid),
    .LD_EN_UX   (LD_EN_UX),
    .LD_EN_UY   (LD_EN_UY),
    .WE_p_mem   (WE_p_mem),
    .WE_ux_mem  (WE_ux_mem),
    .WE_uy_mem  (WE_uy_mem),
    .LD_EN_FEQ  (LD_EN_FEQ),
    .WE_feq_mem (WE_feq_mem),
    .WE_fout_mem(WE_fout_mem)
  );

  rec_t       q[$];
  int         lat_q[$];
  int         lx[GD];
  int         ly[GD];
  int         total = 0;
  int         bad = 0;
  bit         chk_en = 0;
  bit         noise = 0;
  bit         want_start = 0;
  int         chain_left = 0;
  int         dcnt = 0;
  bit         mdl_err = 0;
  int         busy_c, done_c, wp_c, fo_c, rd_c, lp_c;
  logic [8:0] feq_log[$];

  function automatic rec_t mk(int n, bit b, bit e);
    rec_t r;
    r = '{default: '0};
    r.busy = b;
    r.node = n;
    r.err  = e;
    r.dchk = 1'b1;
    return r;
  endfunction

  function automatic void push_wait(int n, bit sel, int cnt);
    rec_t r;
    for (int i = 0; i < cnt; i++) begin
      r = mk(n, 1, 0);
      r.dsel = sel;
      r.wt = 1'b1;
      q.push_back(r);
    end
  endfunction

  // Expected output of every cycle of one sweep, one record per cycle.
  function automatic void push_sweep();
    rec_t r;
    for (int n = 0; n < GD; n++) begin
      r = mk(n, 1, 0); r.clr = 1; q.push_back(r);
      for (int k = 0; k <= 9; k++) begin
        r = mk(n, 1, 0);
        r.rd = (k < 9); r.dir = (k < 9) ? k : 0;
        r.dchk = (k < 9); r.acc = (k >= 1);
        q.push_back(r);
      end
      r = mk(n, 1, 0); r.dst = 1; q.push_back(r);
      lat_q.push_back(lx[n]);
      if (lx[n] == 0) begin
        push_wait(n, 0, TO); q.push_back(mk(0, 0, 1)); return;
      end
      push_wait(n, 0, lx[n]);
      r = mk(n, 1, 0); r.dst = 1; r.dsel = 1; r.lux = 1; q.push_back(r);
      lat_q.push_back(ly[n]);
      if (ly[n] == 0) begin
        push_wait(n, 1, TO); q.push_back(mk(0, 0, 1)); return;
      end
      push_wait(n, 1, ly[n]);
      r = mk(n, 1, 0); r.wmac = 1; r.luy = 1; q.push_back(r);
      for (int d = 0; d < 9; d++) begin
        r = mk(n, 1, 0); r.dir = d; r.feq = 9'(1) << d; r.wfeq = 1;
        q.push_back(r);
      end
      for (int d = 0; d < 9; d++) begin
        r = mk(n, 1, 0); r.dir = d; r.wfout = 1; q.push_back(r);
      end
      q.push_back(mk(n, 1, 0));
    end
    r = mk(0, 0, 0); r.done = 1; q.push_back(r);
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    rec_t        e;
    logic [31:0] a, x;
    if (q.size() > 0) e = q.pop_front();
    else e = mk(0, 0, mdl_err);
    mdl_err = e.err;
    a = {busy, done, err, node_addr, (e.dchk ? dir : 4'd0),
         fin_rd_en, acc_clr, LD_EN_P, LD_EN_PUX, LD_EN_PUY,
         div_start, div_sel, LD_EN_UX, LD_EN_UY,
         WE_p_mem, WE_ux_mem, WE_uy_mem, LD_EN_FEQ,
         WE_feq_mem, WE_fout_mem};
    x = {e.busy, e.done, e.err, 2'(e.node),
         (e.dchk ? 4'(e.dir) : 4'd0),
         e.rd, e.clr, e.acc, e.acc, e.acc,
         e.dst, e.dsel, e.lux, e.luy,
         e.wmac, e.wmac, e.wmac, e.feq, e.wfeq, e.wfout};
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL cycle node=%0d act=%h exp=%h t=%0t",
               e.node, a, x, $time);
    end
    busy_c += int'(busy);
    done_c += int'(done);
    wp_c += int'(WE_p_mem);
    fo_c += int'(WE_fout_mem);
    rd_c += int'(fin_rd_en);
    lp_c += int'(LD_EN_P);
    if (LD_EN_FEQ != '0) feq_log.push_back(LD_EN_FEQ);
  endtask

  task automatic clr_counts();
    busy_c = 0; done_c = 0; wp_c = 0; fo_c = 0; rd_c = 0; lp_c = 0;
    feq_log.delete();
  endtask

  // Compare the finished cycle, then drive inputs for the next one.
  task automatic tick();
    @(negedge Clk);
    if (chk_en) compare();
    @(posedge Clk);
    #1;
    start = 1'b0;
    div_valid = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) div_valid = 1'b1;
    end
    if (noise && dcnt == 0 && (q.size() == 0 || !q[0].wt) &&
        $urandom_range(3) == 0)
      div_valid = 1'b1;
    if (div_start) dcnt = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
    if (want_start) begin
      start = 1'b1;
      want_start = 0;
      if (q.size() == 0) begin
        q.push_back(mk(0, 0, mdl_err));
        push_sweep();
      end else if (!q[0].busy) begin
        push_sweep();
      end
    end else if (chain_left > 0 && q.size() == 1 && q[0].done) begin
      start = 1'b1;
      chain_left--;
      push_sweep();
    end else if (noise && q.size() > 0 && q[0].busy &&
                 $urandom_range(7) == 0) begin
      start = 1'b1;
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((q.size() > 0 || chain_left > 0 || want_start) && i < 3000) begin
      tick();
      i++;
    end
    total++;
    if (i >= 3000) begin
      bad++;
      $display("FAIL drain_timeout left=%0d", q.size());
    end
    tick();
    tick();
  endtask

  task automatic set_lat(int lo, int hi);
    for (int n = 0; n < GD; n++) begin
      lx[n] = $urandom_range(hi, lo);
      ly[n] = $urandom_range(hi, lo);
    end
  endtask

  initial begin
    int exp_busy;
    clr_counts();
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_node", int'(node_addr), 0);
    chk("rst_err", int'(err), 0);
    Reset = 1'b1;
    chk_en = 1;
    tick();

    // abort mid-ACCUM on dir 4
    set_lat(6, 6);
    want_start = 1;
    tick();
    repeat (6) tick();
    chk("accum_dir4", int'(dir), 4);
    chk("accum_rd", int'(fin_rd_en), 1);
    #2;
    chk_en = 0;
    Reset = 1'b0;
    #1;
    chk("abort_all0", int'({busy, done, err, node_addr, dir, fin_rd_en,
        acc_clr, LD_EN_P, LD_EN_PUX, LD_EN_PUY, div_start, div_sel,
        LD_EN_UX, LD_EN_UY, WE_p_mem, WE_ux_mem, WE_uy_mem, LD_EN_FEQ,
        WE_feq_mem, WE_fout_mem}), 0);
    q.delete();
    lat_q.delete();
    dcnt = 0;
    mdl_err = 0;
    tick();
    tick();
    Reset = 1'b1;
    chk_en = 1;
    tick();

    // L=6 sweep with stray start and div_valid pulses
    clr_counts();
    noise = 1;
    set_lat(6, 6);
    want_start = 1;
    drain();
    chk("busy_cycles", busy_c, 180);
    chk("done_pulses", done_c, 1);
    chk("we_p_pulses", wp_c, 4);
    chk("we_fout_pulses", fo_c, 36);
    chk("fin_rd_pulses", rd_c, 36);
    chk("ld_p_pulses", lp_c, 36);
    chk("feq_count", feq_log.size(), 36);
    if (feq_log.size() >= 10) begin
      chk("feq_first", int'(feq_log[0]), 1);
      chk("feq_last", int'(feq_log[8]), 256);
      chk("feq_wrap", int'(feq_log[9]), 1);
    end

    // divider never answers the Y divide of node 2
    clr_counts();
    set_lat(3, 3);
    ly[0] = 4; ly[1] = 5; ly[2] = 0; ly[3] = 7;
    want_start = 1;
    drain();
    chk("to_err", int'(err), 1);
    chk("to_done", done_c, 0);
    chk("to_we_p", wp_c, 2);
    chk("to_node", int'(node_addr), 0);
    set_lat(2, 2);
    want_start = 1;
    tick();
    tick();
    chk("err_cleared", int'(err), 0);
    drain();

    // back-to-back sweeps, second start in the done cycle
    clr_counts();
    set_lat(1, 12);
    exp_busy = 0;
    for (int n = 0; n < GD; n++) exp_busy += 33 + lx[n] + ly[n];
    chain_left = 1;
    want_start = 1;
    drain();
    chk("chain_done", done_c, 2);
    chk("chain_busy", busy_c, 2 * exp_busy);
    chk("wrap_node", int'(node_addr), 0);

    for (int it = 0; it < 4; it++) begin
      noise = bit'($urandom_range(1));
      set_lat(1, 20);
      repeat ($urandom_range(3)) tick();
      want_start = 1;
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
